jtcop_prot_arb: RTL

Arbiter for the 2 kB single-port RAM that the main 68000 and the HuC6280 protection CPU share on Robocop. Both requesters are serialised onto one synchronous RAM port. The block returns read data and a one-cycle acknowledge to the main side, and drives WAIT_N to stall the HuC6280 while it is waiting. It also owns the main-to-protection IRQ latch behind the mailbox address 0x7FF, so the HuC6280's WAIT_N is no longer tied high.

---
 rtl/jtcop_prot_arb_if.sv | 34 +++
 rtl/jtcop_prot_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/jtcop_prot_arb_if.sv
// Bus bundle between the shared-RAM arbiter, its two requesters and the RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface jtcop_prot_arb_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          m_cs;
  logic          m_wrn;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;
  logic          m_ok;
  logic          s_cs;
  logic          s_wrn;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;
  logic          s_waitn;
  logic          irqn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  modport slave (
    input  m_cs, m_wrn, m_addr, m_din, s_cs, s_wrn, s_addr, s_din, ram_q,
    output m_dout, m_ok, s_dout, s_waitn, irqn, ram_addr, ram_data, ram_we
  );

  modport master (
    output m_cs, m_wrn, m_addr, m_din, s_cs, s_wrn, s_addr, s_din, ram_q,
    input  m_dout, m_ok, s_dout, s_waitn, irqn, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/jtcop_prot_arb.sv
// Serialises the 68000 and HuC6280 onto the shared 2 kB RAM port, stalls the
// HuC6280 through WAIT_N and keeps the main-to-protection IRQ mailbox latch.
module jtcop_prot_arb #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  jtcop_prot_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, LAT, ACK} state_t;

  localparam logic [AW-1:0] MBOX = AW'(11'h7FF);

  state_t        st, st_nx;
  logic          m_cs_d, s_cs_d;
  logic          m_pend, s_pend;
  logic          last_s, gnt_s, gnt_s_nx;
  logic          s_done_r;
  logic          start, ack;
  logic          m_edge, s_edge;
  logic          m_wr_r, s_wr_r;
  logic [AW-1:0] m_addr_r, s_addr_r;
  logic [DW-1:0] m_din_r, s_din_r;
  logic          sel_wr, cur_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic          irq_set, irq_clr;
  logic          irqn_r, ram_we_r;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_data_r, m_dout_r, s_dout_r;

  assign m_edge = bus.m_cs & ~m_cs_d;
  assign s_edge = bus.s_cs & ~s_cs_d;

  always_comb begin
    st_nx    = st;
    gnt_s_nx = gnt_s;
    start    = 1'b0;
    case (st)
      IDLE: begin
        if (m_pend | s_pend) begin
          start    = 1'b1;
          // on a tie the side that was not served last wins
          gnt_s_nx = s_pend & (~m_pend | ~last_s);
          st_nx    = ACC;
        end
      end
      ACC:     st_nx = LAT;
      LAT:     st_nx = ACK;
      ACK:     st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign ack      = (st == ACK);
  assign sel_wr   = gnt_s_nx ? s_wr_r   : m_wr_r;
  assign sel_addr = gnt_s_nx ? s_addr_r : m_addr_r;
  assign sel_din  = gnt_s_nx ? s_din_r  : m_din_r;
  assign cur_wr   = gnt_s ? s_wr_r : m_wr_r;

  // mailbox latch moves together with ram_addr, i.e. it is visible in ACC
  assign irq_set = start & ~gnt_s_nx &  m_wr_r & (m_addr_r == MBOX);
  assign irq_clr = start &  gnt_s_nx & ~s_wr_r & (s_addr_r == MBOX);

  always_ff @(posedge clk) begin
    m_cs_d <= bus.m_cs;
    s_cs_d <= bus.s_cs;
    if (rst) begin
      st       <= IDLE;
      gnt_s    <= 1'b0;
      last_s   <= 1'b1;
      m_pend   <= 1'b0;
      s_pend   <= 1'b0;
      s_done_r <= 1'b0;
      ram_we_r <= 1'b0;
      irqn_r   <= 1'b1;
    end else begin
      st       <= st_nx;
      gnt_s    <= gnt_s_nx;
      ram_we_r <= start & sel_wr;
      if (start) last_s <= gnt_s_nx;
      if (m_edge)              m_pend <= 1'b1;
      else if (ack && !gnt_s)  m_pend <= 1'b0;
      if (s_edge)              s_pend <= 1'b1;
      else if (ack && gnt_s)   s_pend <= 1'b0;
      if (!bus.s_cs)           s_done_r <= 1'b0;
      else if (ack && gnt_s)   s_done_r <= 1'b1;
      if (irq_set)             irqn_r <= 1'b0;
      else if (irq_clr)        irqn_r <= 1'b1;
    end
  end

  // request attributes are frozen at the cs edge
  always_ff @(posedge clk) begin
    if (m_edge) begin
      m_wr_r   <= ~bus.m_wrn;
      m_addr_r <= bus.m_addr;
      m_din_r  <= bus.m_din;
    end
    if (s_edge) begin
      s_wr_r   <= ~bus.s_wrn;
      s_addr_r <= bus.s_addr;
      s_din_r  <= bus.s_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_r <= '0;
      ram_data_r <= '0;
      m_dout_r   <= '0;
      s_dout_r   <= '0;
    end else begin
      if (start) begin
        ram_addr_r <= sel_addr;
        ram_data_r <= sel_din;
      end
      if (st == LAT && !cur_wr) begin
        if (gnt_s) s_dout_r <= bus.ram_q;
        else       m_dout_r <= bus.ram_q;
      end
    end
  end

  assign bus.m_ok     = ack & ~gnt_s;
  assign bus.s_waitn  = ~(bus.s_cs & ~(s_done_r | (ack & gnt_s)));
  assign bus.irqn     = irqn_r;
  assign bus.ram_we   = ram_we_r;
  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_data = ram_data_r;
  assign bus.m_dout   = m_dout_r;
  assign bus.s_dout   = s_dout_r;

endmodule
